// File: rtl/block_ram_fifo.sv
// block_ram_fifo: byte-maskable simple dual-port RAM that can also run as a FIFO.
//   clk, rst_n      : single clock, asynchronous active-low reset
//   C0              : 0 = RAM mode, 1 = FIFO mode
//   C1              : 1 = extra output register (read latency 2 instead of 1)
//   wr_en/wr_addr/wr_data/wr_mask : write port (addr and mask used in RAM mode only)
//   rd_en/rd_addr   : read request / pop (addr used in RAM mode only)
//   rd_data/rd_valid: read data and its one-cycle valid pulse
//   full/empty/almost_full/count  : registered FIFO status
//   overflow/underflow            : one-cycle pulses for rejected push/pop

// One byte lane of storage; write synchronous, read combinational into the
// top-level read register.
module bram_lane #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);
  logic [7:0] mem_q [2**AW];

  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;

  assign rdata_o = mem_q[raddr_i];
endmodule

module block_ram_fifo #(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDR_WIDTH         = 8,
  parameter int ALMOST_FULL_MARGIN = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    C0,
  input  logic                    C1,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_mask,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic [ADDR_WIDTH:0]     count,
  output logic                    overflow,
  output logic                    underflow
);
  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam int NUM_LANES = DATA_WIDTH / 8;
  localparam int STAGES    = 2;
  typedef logic [ADDR_WIDTH:0]   cnt_t;
  typedef logic [ADDR_WIDTH-1:0] ptr_t;

  logic                  mode_q, mode_chg, op_ok;
  ptr_t                  wptr_q, wptr_d, rptr_q, rptr_d, mem_waddr, mem_raddr;
  cnt_t                  cnt_q, cnt_d;
  logic                  full_q, empty_q, af_q, ovf_q, udf_q;
  logic                  push_ok, pop_ok, ram_wr, ram_rd, rd_req;
  logic [NUM_LANES-1:0]  lane_we;
  logic [NUM_LANES-1:0][7:0] mem_rdata;
  logic [STAGES:1]       vld_pipe_q;
  logic [DATA_WIDTH-1:0] s1_q, out_q;

  // A mode flip is seen against the registered copy; that cycle only clears.
  assign mode_chg = C0 ^ mode_q;
  assign op_ok    = ~mode_chg;

  always_comb begin
    push_ok   = op_ok & mode_q & wr_en & ~full_q;
    pop_ok    = op_ok & mode_q & rd_en & ~empty_q;
    ram_wr    = op_ok & ~mode_q & wr_en;
    ram_rd    = op_ok & ~mode_q & rd_en;
    rd_req    = pop_ok | ram_rd;
    lane_we   = mode_q ? {NUM_LANES{push_ok}} : (wr_mask & {NUM_LANES{ram_wr}});
    mem_waddr = mode_q ? wptr_q : wr_addr;
    mem_raddr = mode_q ? rptr_q : rd_addr;
    // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
    wptr_d    = wptr_q + ptr_t'(push_ok);
    rptr_d    = rptr_q + ptr_t'(pop_ok);
    cnt_d     = cnt_q + cnt_t'(push_ok) - cnt_t'(pop_ok);
    if (mode_chg) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    bram_lane #(.AW(ADDR_WIDTH)) u_lane (
      .clk     (clk),
      .we_i    (lane_we[g]),
      .waddr_i (mem_waddr),
      .wdata_i (wr_data[8*g +: 8]),
      .raddr_i (mem_raddr),
      .rdata_o (mem_rdata[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= C0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      vld_pipe_q <= '0;
      s1_q       <= '0;
      out_q      <= '0;
    end else begin
      mode_q     <= C0;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      // In RAM mode cnt_d stays 0, so flags sit at their reset values.
      full_q     <= (cnt_d == cnt_t'(DEPTH));
      empty_q    <= (cnt_d == '0);
      af_q       <= (cnt_d >= cnt_t'(DEPTH - ALMOST_FULL_MARGIN));
      ovf_q      <= op_ok & mode_q & wr_en & full_q;
      udf_q      <= op_ok & mode_q & rd_en & empty_q;
      vld_pipe_q <= {vld_pipe_q[STAGES-1:1], rd_req};
      if (rd_req)        s1_q  <= mem_rdata;
      if (vld_pipe_q[1]) out_q <= s1_q;
    end
  end

  assign rd_data     = C1 ? out_q : s1_q;
  assign rd_valid    = C1 ? vld_pipe_q[2] : vld_pipe_q[1];
  assign full        = full_q;
  assign empty       = empty_q;
  assign almost_full = af_q;
  assign count       = cnt_q;
  assign overflow    = ovf_q;
  assign underflow   = udf_q;
endmodule

// File: tb/tb_block_ram_fifo.sv
module tb_block_ram_fifo;
  logic        clk = 0, rst_n = 0, C0 = 0, C1 = 0;
  logic        wr_en = 0, rd_en = 0;
  logic [7:0]  wr_addr = 0, rd_addr = 0;
  logic [31:0] wr_data = 0;
  logic [3:0]  wr_mask = 0;
  logic [31:0] rd_data;
  logic        rd_valid, full, empty, almost_full, overflow, underflow;
  logic [8:0]  count;
  int n_cmp = 0, n_err = 0;

  block_ram_fifo dut (
    .clk(clk), .rst_n(rst_n), .C0(C0), .C1(C1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .full(full), .empty(empty), .almost_full(almost_full), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    wr_en = 0; rd_en = 0;
  endtask

  // Two mode flips; each flip cycle clears pointers and count.
  task automatic fifo_clear();
    idle(); C0 = 0; tick(); C0 = 1; tick();
  endtask

  task automatic test_reset();
    rst_n = 0; C0 = 0; C1 = 0; idle();
    tick(); tick();
    n_cmp++;
    if ({rd_valid, full, empty, almost_full, overflow, underflow} !== 6'b001000) begin
      n_err++; $display("FAIL reset_flags: got %b want 001000",
        {rd_valid, full, empty, almost_full, overflow, underflow});
    end
    n_cmp++;
    if (count !== 9'd0 || rd_data !== 32'd0) begin
      n_err++; $display("FAIL reset_cnt_data: got count=%0d data=%h want 0/0", count, rd_data);
    end
    rst_n = 1; tick();
  endtask

  task automatic test_ram_c1_0();
    C0 = 0; C1 = 0;
    wr_en = 1; wr_addr = 8'h05; wr_data = 32'hDEADBEEF; wr_mask = 4'b1111; tick();
    wr_data = 32'h00001200; wr_mask = 4'b0010; tick();
    wr_en = 0; rd_en = 1; rd_addr = 8'h05; tick();
    rd_en = 0;
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== 32'hDEAD12EF) begin
      n_err++; $display("FAIL ram_lat1_read: got v=%b d=%h want 1/DEAD12EF", rd_valid, rd_data);
    end
    tick();
    n_cmp++;
    if (rd_valid !== 1'b0 || rd_data !== 32'hDEAD12EF) begin
      n_err++; $display("FAIL ram_hold: got v=%b d=%h want 0/DEAD12EF", rd_valid, rd_data);
    end
    n_cmp++;
    if ({full, empty, almost_full, overflow, underflow} !== 5'b01000 || count !== 9'd0) begin
      n_err++; $display("FAIL ram_flags: got %b count=%0d want 01000/0",
        {full, empty, almost_full, overflow, underflow}, count);
    end
  endtask

  task automatic test_ram_c1_1();
    C0 = 0; C1 = 1;
    rd_en = 1; rd_addr = 8'h05; tick();
    rd_en = 0;
    n_cmp++;
    if (rd_valid !== 1'b0) begin
      n_err++; $display("FAIL ram_lat2_early: got v=%b want 0", rd_valid);
    end
    tick();
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== 32'hDEAD12EF) begin
      n_err++; $display("FAIL ram_lat2_read: got v=%b d=%h want 1/DEAD12EF", rd_valid, rd_data);
    end
    // Same-address read and write in one cycle returns the old word.
    wr_en = 1; wr_addr = 8'h05; wr_data = 32'h11223344; wr_mask = 4'b1111;
    rd_en = 1; rd_addr = 8'h05; tick();
    idle(); tick();
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== 32'hDEAD12EF) begin
      n_err++; $display("FAIL ram_rbw_old: got v=%b d=%h want 1/DEAD12EF", rd_valid, rd_data);
    end
    rd_en = 1; tick(); rd_en = 0; tick();
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h11223344) begin
      n_err++; $display("FAIL ram_rbw_new: got v=%b d=%h want 1/11223344", rd_valid, rd_data);
    end
  endtask

  task automatic test_fifo_fill_drain();
    C1 = 0; idle(); C0 = 1; tick();
    for (int i = 0; i < 256; i++) begin
      wr_en = 1; wr_data = 32'hA5000000 | i; tick();
      if (i == 250 || i == 251) begin
        n_cmp++;
        if (almost_full !== (i == 251)) begin
          n_err++; $display("FAIL fifo_af_at_%0d: got %b want %b", i + 1, almost_full, i == 251);
        end
      end
    end
    n_cmp++;
    if (full !== 1'b1 || count !== 9'd256 || empty !== 1'b0) begin
      n_err++; $display("FAIL fifo_full: got full=%b count=%0d empty=%b want 1/256/0", full, count, empty);
    end
    wr_data = 32'hFFFFFFFF; tick();
    wr_en = 0;
    n_cmp++;
    if (overflow !== 1'b1 || count !== 9'd256) begin
      n_err++; $display("FAIL fifo_ovf: got ovf=%b count=%0d want 1/256", overflow, count);
    end
    tick();
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_err++; $display("FAIL fifo_ovf_pulse: got %b want 0", overflow);
    end
    for (int i = 0; i < 256; i++) begin
      rd_en = 1; tick();
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_data !== (32'hA5000000 | i)) begin
        n_err++; $display("FAIL fifo_drain_%0d: got v=%b d=%h want 1/%h",
          i, rd_valid, rd_data, 32'hA5000000 | i);
      end
    end
    rd_en = 0;
    n_cmp++;
    if (empty !== 1'b1 || count !== 9'd0 || full !== 1'b0 || almost_full !== 1'b0) begin
      n_err++; $display("FAIL fifo_empty: got e=%b c=%0d f=%b af=%b want 1/0/0/0",
        empty, count, full, almost_full);
    end
  endtask

  task automatic test_fifo_edges();
    C1 = 0;
    wr_en = 1; rd_en = 1; wr_data = 32'h0BADF00D; tick();
    n_cmp++;
    if (underflow !== 1'b1 || rd_valid !== 1'b0 || count !== 9'd1 || empty !== 1'b0) begin
      n_err++; $display("FAIL edge_empty_pp: got udf=%b v=%b c=%0d e=%b want 1/0/1/0",
        underflow, rd_valid, count, empty);
    end
    wr_en = 0; tick();
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h0BADF00D || count !== 9'd0 || underflow !== 1'b0) begin
      n_err++; $display("FAIL edge_pop_one: got v=%b d=%h c=%0d udf=%b want 1/0BADF00D/0/0",
        rd_valid, rd_data, count, underflow);
    end
    rd_en = 0;
    for (int i = 0; i < 256; i++) begin
      wr_en = 1; wr_data = 32'h1000 + i; tick();
    end
    wr_en = 1; rd_en = 1; wr_data = 32'hFFFF0000; tick();
    idle();
    n_cmp++;
    if (overflow !== 1'b1 || rd_valid !== 1'b1 || rd_data !== 32'h1000 ||
        count !== 9'd255 || full !== 1'b0) begin
      n_err++; $display("FAIL edge_full_pp: got ovf=%b v=%b d=%h c=%0d f=%b want 1/1/00001000/255/0",
        overflow, rd_valid, rd_data, count, full);
    end
  endtask

  task automatic test_fifo_mixed();
    logic [31:0] q[$];
    logic [31:0] d, popd, p1d, p2d;
    bit w, r, pok, wok, p1v, p2v;
    fifo_clear(); C1 = 1;
    p1v = 0; p2v = 0; p1d = 0; p2d = 0;
    for (int i = 0; i < 200; i++) begin
      d = $urandom; q.push_back(d); wr_en = 1; wr_data = d; tick();
    end
    idle(); tick(); tick();
    for (int i = 0; i < 302; i++) begin
      w = (i < 300) ? 1'($urandom) : 1'b0;
      r = (i < 300) ? 1'($urandom) : 1'b0;
      d = $urandom;
      pok = r && q.size() > 0;
      wok = w && q.size() < 256;
      popd = pok ? q.pop_front() : 32'd0;
      if (wok) q.push_back(d);
      wr_en = w; rd_en = r; wr_data = d; tick();
      p2v = p1v; p2d = p1d; p1v = pok; p1d = popd;
      n_cmp++;
      if (rd_valid !== p2v || (p2v && rd_data !== p2d) || count !== 9'(q.size())) begin
        n_err++; $display("FAIL mixed_%0d: got v=%b d=%h c=%0d want %b/%h/%0d",
          i, rd_valid, rd_data, count, p2v, p2d, q.size());
      end
    end
    idle();
  endtask

  task automatic test_mode_toggle();
    fifo_clear(); C1 = 0;
    for (int i = 0; i < 10; i++) begin
      wr_en = 1; wr_data = i; tick();
    end
    wr_en = 0;
    n_cmp++;
    if (count !== 9'd10) begin
      n_err++; $display("FAIL toggle_pre: got count=%0d want 10", count);
    end
    C0 = 0; wr_en = 1; tick();
    wr_en = 0;
    n_cmp++;
    if (count !== 9'd0 || empty !== 1'b1) begin
      n_err++; $display("FAIL toggle_clear: got c=%0d e=%b want 0/1", count, empty);
    end
    C0 = 1; tick();
  endtask

  task automatic test_reset_midread();
    fifo_clear(); C1 = 1;
    wr_en = 1; wr_data = 32'h77; tick();
    wr_en = 0; rd_en = 1; tick();
    rd_en = 0; rst_n = 0; #1;
    n_cmp++;
    if ({rd_valid, full, empty, almost_full, overflow, underflow} !== 6'b001000 ||
        count !== 9'd0 || rd_data !== 32'd0) begin
      n_err++; $display("FAIL rst_mid: got %b c=%0d d=%h want 001000/0/0",
        {rd_valid, full, empty, almost_full, overflow, underflow}, count, rd_data);
    end
    tick(); rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (rd_valid !== 1'b0 || rd_data !== 32'd0) begin
        n_err++; $display("FAIL rst_no_valid_%0d: got v=%b d=%h want 0/0", i, rd_valid, rd_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ram_c1_0();
    test_ram_c1_1();
    test_fifo_fill_drain();
    test_fifo_edges();
    test_fifo_mixed();
    test_mode_toggle();
    test_reset_midread();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
